// File: rtl/iram_boot_loader_pkg.sv
// Shared types and constants for the IRAM boot loader.
// Optional feature macro: IRAM_BOOT_LOADER_CHECKSUM_EN (trailing checksum word).
package iram_boot_loader_pkg;

    localparam int IRAM_DEPTH  = 21504;
    localparam int IRAM_ADDR_W = 15;

    // Byte lane within a 32-bit word, lane 0 = bits 7:0.
    typedef logic [1:0] lane_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } boot_state_t;

endpackage

// File: rtl/iram_boot_loader_byte_pack32.sv
// Little-endian byte-to-word packer. word_o always shows the word with the
// current byte merged in, so word_o is complete in the same cycle word_valid_o
// strobes on the fourth byte.
module byte_pack32
    import iram_boot_loader_pkg::*;
(
    input  logic        clk_a,
    input  logic        reset,
    input  logic        clear_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    lane_idx_t   idx_q;
    logic [31:0] word_q;

    // Merge the incoming byte into its lane and flag the fourth byte.
    always_comb begin
        word_o = word_q;
        if (byte_valid_i) begin
            word_o[{idx_q, 3'b000} +: 8] = byte_i;
        end
        word_valid_o = byte_valid_i && (idx_q == 2'd3);
    end

    // Lane index and partial word; a completed word starts the next one clean.
    always_ff @(posedge clk_a) begin
        if (reset || clear_i) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (byte_valid_i) begin
            idx_q  <= idx_q + 2'd1;
            word_q <= word_valid_o ? 32'h0 : word_o;
        end
    end

endmodule

// File: rtl/iram_boot_loader.sv
// Boot loader filling IRAM port A from a byte stream, little-endian packed.
// Optional feature macro: IRAM_BOOT_LOADER_CHECKSUM_EN adds a CHECK state,
// the checksum_o port and a running 32-bit sum verified against four
// trailing stream bytes.
module iram_boot_loader
    import iram_boot_loader_pkg::*;
#(
    parameter int DEPTH  = IRAM_DEPTH,
    parameter int ADDR_W = IRAM_ADDR_W
) (
    input  logic              clk_a,
    input  logic              reset,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] word_count_i,
    input  logic [7:0]        s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic [ADDR_W-1:0] ram_address_o,
    output logic [31:0]       ram_data_o,
    output logic              ram_wren_o,
    output logic              ram_rden_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
`ifdef IRAM_BOOT_LOADER_CHECKSUM_EN
    output logic [31:0]       checksum_o,
`endif
    output logic [ADDR_W-1:0] words_written_o
);

    boot_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] words_q;
    logic [31:0]       ram_data_q;
    logic              wren_q, wren_d;
    logic              ready_q, ready_d;
`ifdef IRAM_BOOT_LOADER_CHECKSUM_EN
    logic [31:0]       sum_q;
`endif

    logic              start_acc;
    logic              range_ok;
    logic              last_word;
    logic [ADDR_W:0]   end_sum;
    logic              byte_acc;
    logic [31:0]       pack_word;
    logic              pack_valid;

    assign byte_acc  = s_valid_i && ready_q;
    assign end_sum   = {1'b0, base_addr_i} + {1'b0, word_count_i};
    assign range_ok  = (end_sum <= (ADDR_W+1)'(DEPTH));
    assign last_word = ((words_q + {{(ADDR_W-1){1'b0}}, 1'b1}) == count_q);

    byte_pack32 u_pack (
        .clk_a        (clk_a),
        .reset        (reset),
        .clear_i      (start_acc),
        .byte_i       (s_data_i),
        .byte_valid_i (byte_acc),
        .word_o       (pack_word),
        .word_valid_o (pack_valid)
    );

    // Next-state decode; handshake and write strobe follow the next state so they register cleanly.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    if (!range_ok) begin
                        state_d = ST_ERROR;
                    end else if (word_count_i == '0) begin
`ifdef IRAM_BOOT_LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                if (pack_valid) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (last_word) begin
`ifdef IRAM_BOOT_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_COLLECT;
                end
            end
`ifdef IRAM_BOOT_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (pack_valid) state_d = (pack_word == sum_q) ? ST_DONE : ST_ERROR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_COLLECT) || (state_d == ST_CHECK);
        wren_d  = (state_d == ST_WRITE);
    end

    // State, port-A drive and load counters.
    always_ff @(posedge clk_a) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            words_q    <= '0;
            ram_data_q <= '0;
            wren_q     <= 1'b0;
            ready_q    <= 1'b0;
`ifdef IRAM_BOOT_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            wren_q  <= wren_d;
            ready_q <= ready_d;
            if (start_acc) begin
                addr_q  <= base_addr_i;
                count_q <= word_count_i;
                words_q <= '0;
`ifdef IRAM_BOOT_LOADER_CHECKSUM_EN
                sum_q   <= '0;
`endif
            end else if (state_q == ST_WRITE) begin
                addr_q  <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                words_q <= words_q + {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef IRAM_BOOT_LOADER_CHECKSUM_EN
                sum_q   <= sum_q + ram_data_q;
`endif
            end
            if ((state_q == ST_COLLECT) && pack_valid) begin
                ram_data_q <= pack_word;
            end
        end
    end

    assign s_ready_o       = ready_q;
    assign ram_address_o   = addr_q;
    assign ram_data_o      = ram_data_q;
    assign ram_wren_o      = wren_q;
    assign ram_rden_o      = 1'b0;
    assign busy_o          = (state_q == ST_COLLECT) || (state_q == ST_WRITE) || (state_q == ST_CHECK);
    assign done_o          = (state_q == ST_DONE);
    assign error_o         = (state_q == ST_ERROR);
    assign words_written_o = words_q;
`ifdef IRAM_BOOT_LOADER_CHECKSUM_EN
    assign checksum_o      = sum_q;
`endif

endmodule

// File: tb/tb_iram_boot_loader.sv
// Directed bench for iram_boot_loader: an IRAM image model plus an
// expected-write queue built from the byte stream, checked every cycle.
module tb_iram_boot_loader;

    logic        clk_a;
    logic        reset;
    logic        start_i;
    logic [14:0] base_addr_i;
    logic [14:0] word_count_i;
    logic [7:0]  s_data_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [14:0] ram_address_o;
    logic [31:0] ram_data_o;
    logic        ram_wren_o;
    logic        ram_rden_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic [14:0] words_written_o;
`ifdef IRAM_BOOT_LOADER_CHECKSUM_EN
    logic [31:0] checksum_o;
`endif

    int total = 0;
    int bad   = 0;
    int wren_cnt = 0;
    logic        prev_wren = 1'b0;
    logic [46:0] expq[$];
    logic [7:0]  data_q[$];
    logic [7:0]  stim_q[$];
    logic [31:0] mem[int];

    iram_boot_loader dut (
        .clk_a           (clk_a),
        .reset           (reset),
        .start_i         (start_i),
        .base_addr_i     (base_addr_i),
        .word_count_i    (word_count_i),
        .s_data_i        (s_data_i),
        .s_valid_i       (s_valid_i),
        .s_ready_o       (s_ready_o),
        .ram_address_o   (ram_address_o),
        .ram_data_o      (ram_data_o),
        .ram_wren_o      (ram_wren_o),
        .ram_rden_o      (ram_rden_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .error_o         (error_o),
`ifdef IRAM_BOOT_LOADER_CHECKSUM_EN
        .checksum_o      (checksum_o),
`endif
        .words_written_o (words_written_o)
    );

    initial clk_a = 1'b0;
    always #5 clk_a = ~clk_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_mem(input int a);
        return mem.exists(a) ? mem[a] : 32'hDEAD_DEAD;
    endfunction

    // Every cycle: rden stays low, each write matches the next expected write, pulses are single-cycle.
    always @(negedge clk_a) begin
        if (!reset) begin
            logic [46:0] e;
            chk("rden_low", {31'b0, ram_rden_o}, 32'h0);
            if (ram_wren_o) begin
                chk("wren_single_cycle", {31'b0, prev_wren}, 32'h0);
                if (expq.size() == 0) begin
                    chk("unexpected_write", {17'b0, ram_address_o}, 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    chk("wr_addr", {17'b0, ram_address_o}, {17'b0, e[46:32]});
                    chk("wr_data", ram_data_o, e[31:0]);
                end
                mem[int'(ram_address_o)] = ram_data_o;
                wren_cnt++;
            end
            prev_wren = ram_wren_o;
        end else begin
            prev_wren = 1'b0;
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic pulse_start(input logic [14:0] b, input logic [14:0] c);
        start_i      = 1'b1;
        base_addr_i  = b;
        word_count_i = c;
        @(posedge clk_a); #1;
        start_i = 1'b0;
    endtask

    task automatic send_stream(input int gap_pct, input int budget);
        int i = 0;
        int cyc = 0;
        while (i < stim_q.size() && cyc < budget) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_valid_i = 1'b0;
            end else begin
                s_valid_i = 1'b1;
                s_data_i  = stim_q[i];
            end
            @(negedge clk_a);
            if (s_valid_i && s_ready_o) i++;
            @(posedge clk_a); #1;
            cyc++;
        end
        s_valid_i = 1'b0;
        chk("stream_bytes_accepted", i, stim_q.size());
    endtask

    task automatic wait_end(input int budget);
        int c = 0;
        while (!(done_o || error_o) && c < budget) begin
            @(posedge clk_a); #1;
            c++;
        end
        chk("end_within_budget", {31'b0, (c < budget)}, 32'h1);
    endtask

    // Model: words are consecutive little-endian groups of data_q written from base upward.
    task automatic run_load(input logic [14:0] base, input logic [14:0] cnt, input int gap,
                            input logic [31:0] csum_xor, input bit expect_ok);
        logic [31:0] w;
        logic [31:0] sum;
        sum = 32'h0;
        expq.delete();
        stim_q = data_q;
        for (int k = 0; k < int'(cnt); k++) begin
            w = {data_q[4*k+3], data_q[4*k+2], data_q[4*k+1], data_q[4*k]};
            expq.push_back({15'(int'(base) + k), w});
            sum = sum + w;
        end
`ifdef IRAM_BOOT_LOADER_CHECKSUM_EN
        for (int j = 0; j < 4; j++) stim_q.push_back(8'((sum ^ csum_xor) >> (8*j)));
`endif
        pulse_start(base, cnt);
        chk("ready_after_start", {31'b0, s_ready_o}, 32'h1);
        chk("busy_after_start", {31'b0, busy_o}, 32'h1);
        send_stream(gap, 3000);
        wait_end(50);
        chk("done_flag", {31'b0, done_o}, {31'b0, expect_ok});
        chk("error_flag", {31'b0, error_o}, {31'b0, !expect_ok});
        chk("busy_end", {31'b0, busy_o}, 32'h0);
        chk("words_written", {17'b0, words_written_o}, {17'b0, cnt});
        chk("all_writes_seen", expq.size(), 0);
`ifdef IRAM_BOOT_LOADER_CHECKSUM_EN
        chk("checksum_out", checksum_o, sum);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_ready"}, {31'b0, s_ready_o}, 32'h0);
        chk({tag, "_wren"}, {31'b0, ram_wren_o}, 32'h0);
        chk({tag, "_addr"}, {17'b0, ram_address_o}, 32'h0);
        chk({tag, "_data"}, ram_data_o, 32'h0);
        chk({tag, "_flags"}, {29'b0, busy_o, done_o, error_o}, 32'h0);
        chk({tag, "_words"}, {17'b0, words_written_o}, 32'h0);
    endtask

    initial begin
        reset        = 1'b1;
        start_i      = 1'b0;
        base_addr_i  = '0;
        word_count_i = '0;
        s_data_i     = '0;
        s_valid_i    = 1'b0;
        repeat (3) @(posedge clk_a);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk_a); #1;

        // Gap-free load of three words.
        data_q.delete();
        for (int b = 1; b <= 12; b++) data_q.push_back(8'(b));
        run_load(15'h0100, 15'd3, 0, 32'h0, 1'b1);
        chk("img_0100", rd_mem(32'h100), 32'h0403_0201);
        chk("img_0101", rd_mem(32'h101), 32'h0807_0605);
        chk("img_0102", rd_mem(32'h102), 32'h0C0B_0A09);
        chk("wren_count_3", wren_cnt, 3);

        // Same load with roughly half the cycles idle on the stream.
        mem.delete();
        wren_cnt = 0;
        run_load(15'h0100, 15'd3, 50, 32'h0, 1'b1);
        chk("gap_img_0100", rd_mem(32'h100), 32'h0403_0201);
        chk("gap_img_0101", rd_mem(32'h101), 32'h0807_0605);
        chk("gap_img_0102", rd_mem(32'h102), 32'h0C0B_0A09);
        chk("gap_wren_count", wren_cnt, 3);

        // 0x53FF + 2 = 21505 exceeds the IRAM.
        wren_cnt = 0;
        pulse_start(15'h53FF, 15'd2);
        chk("range_error", {31'b0, error_o}, 32'h1);
        chk("range_done_low", {31'b0, done_o}, 32'h0);
        chk("range_ready_low", {31'b0, s_ready_o}, 32'h0);
        s_valid_i = 1'b1;
        s_data_i  = 8'h55;
        repeat (6) @(posedge clk_a);
        #1;
        s_valid_i = 1'b0;
        chk("range_ready_still_low", {31'b0, s_ready_o}, 32'h0);
        chk("range_error_held", {31'b0, error_o}, 32'h1);
        chk("range_no_writes", wren_cnt, 0);

        // Last IRAM word exactly fits.
        mem.delete();
        data_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(15'h53FF, 15'd1, 0, 32'h0, 1'b1);
        chk("img_53ff", rd_mem(32'h53FF), 32'h4433_2211);
        chk("top_wren_count", wren_cnt, 1);

`ifndef IRAM_BOOT_LOADER_CHECKSUM_EN
        // Zero-length load finishes immediately without writing.
        wren_cnt = 0;
        pulse_start(15'h0010, 15'd0);
        chk("zero_done", {31'b0, done_o}, 32'h1);
        chk("zero_busy", {31'b0, busy_o}, 32'h0);
        repeat (3) @(posedge clk_a);
        #1;
        chk("zero_no_writes", wren_cnt, 0);
`endif

        // Reset after two bytes of the first word, then reload cleanly.
        pulse_start(15'h0200, 15'd2);
        stim_q = '{8'h01, 8'h02};
        send_stream(0, 100);
        reset = 1'b1;
        @(posedge clk_a); #1;
        check_all_zero("midreset");
        reset = 1'b0;
        expq.delete();
        mem.delete();
        wren_cnt = 0;
        @(posedge clk_a); #1;
        data_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(15'h0200, 15'd1, 0, 32'h0, 1'b1);
        chk("reload_img_0200", rd_mem(32'h200), 32'hDDCC_BBAA);
        chk("reload_wren_count", wren_cnt, 1);

`ifdef IRAM_BOOT_LOADER_CHECKSUM_EN
        // 0x00000001 + 0xFFFFFFFF wraps to zero.
        data_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_load(15'h0000, 15'd2, 0, 32'h0, 1'b1);
        chk("csum_ok_value", checksum_o, 32'h0);
        run_load(15'h0000, 15'd2, 0, 32'h1, 1'b0);
        chk("csum_bad_value", checksum_o, 32'h0);
        chk("csum_bad_error", {31'b0, error_o}, 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
